// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the EXE-stage data-SRAM request path.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } memState_e;

    function automatic logic [3:0] wstrb_gen(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] strb;
        case (size)
            SZ_B:    strb = 4'b0001 << addr;
            SZ_H:    strb = 4'b0011 << {addr[1], 1'b0};
            SZ_W:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/mem_resp_filter.sv
// Tracks accepted-but-unanswered requests and hides data_ok pulses that belong
// to instructions killed by a writeback flush.
module mem_resp_filter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic accept_i,
    input  logic doomed_accept_i,
    input  logic data_ok_i,
    input  logic flush_i,
    output logic can_issue_o,
    output logic ms_data_ok_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic          discardHit;

    assign discardHit   = data_ok_i && (discard_q != '0);
    assign ms_data_ok_o = data_ok_i && !discardHit;
    assign can_issue_o  = outstanding_q < MAX_CNT;

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept_i && !data_ok_i) begin
            outstanding_d = outstanding_q + ONE;
        end else if (!accept_i && data_ok_i) begin
            outstanding_d = outstanding_q - ONE;
        end
    end

    // A flush condemns everything in flight, including this cycle's acceptance.
    always_comb begin
        discard_d = discard_q;
        if (flush_i) begin
            discard_d = outstanding_d;
        end else if (doomed_accept_i && !discardHit) begin
            discard_d = discard_q + ONE;
        end else if (!doomed_accept_i && discardHit) begin
            discard_d = discard_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule

// File: rtl/exe_mem_req.sv
// EXE-stage memory request issue: registers a load/store request, holds it until
// addr_ok, raises alignment exceptions and stalls EXE through the address phase.
module exe_mem_req #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_valid_i,
    input  logic        es_mem_re_i,
    input  logic        es_mem_we_i,
    input  logic [1:0]  es_size_i,
    input  logic [31:0] es_addr_i,
    input  logic [31:0] es_st_data_i,
    input  logic        es_ex_in_i,
    input  logic        ms_ex_i,
    input  logic        wb_flush_i,
    input  logic        ms_allowin_i,
    output logic        data_sram_req_o,
    output logic        data_sram_wr_o,
    output logic [1:0]  data_sram_size_o,
    output logic [3:0]  data_sram_wstrb_o,
    output logic [31:0] data_sram_addr_o,
    output logic [31:0] data_sram_wdata_o,
    input  logic        data_sram_addr_ok_i,
    input  logic        data_sram_data_ok_i,
    output logic        es_ready_go_o,
    output logic        es_ale_o,
    output logic        ms_data_ok_o
);

    import mem_pkg::*;

    memState_e   state_q;
    logic        req_q, doomed_q, wr_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] addr_q, wdata_q, wdata_d;
    logic        memOp, go, canIssue, accept, doomedAccept;

    assign memOp = es_valid_i && (es_mem_re_i || es_mem_we_i);
    assign es_ale_o = memOp && (((es_size_i == SZ_H) && es_addr_i[0]) ||
                                ((es_size_i == SZ_W) && (es_addr_i[1:0] != 2'b00)));

    assign go = memOp && !es_ale_o && !es_ex_in_i && !ms_ex_i && !wb_flush_i &&
                canIssue && (state_q == IDLE);

    assign wstrb_d = es_mem_we_i ? wstrb_gen(es_size_i, es_addr_i[1:0]) : 4'b0000;

    always_comb begin
        case (es_size_i)
            SZ_B:    wdata_d = {4{es_st_data_i[7:0]}};
            SZ_H:    wdata_d = {2{es_st_data_i[15:0]}};
            default: wdata_d = es_st_data_i;
        endcase
    end

    assign accept       = req_q && data_sram_addr_ok_i;
    assign doomedAccept = accept && doomed_q;

    // Once raised, req stays up with a frozen payload until addr_ok, even across a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            doomed_q <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'b00;
            wstrb_q  <= 4'b0000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        state_q  <= REQ;
                        req_q    <= 1'b1;
                        doomed_q <= 1'b0;
                        wr_q     <= es_mem_we_i;
                        size_q   <= es_size_i;
                        wstrb_q  <= wstrb_d;
                        addr_q   <= es_addr_i;
                        wdata_q  <= wdata_d;
                    end
                end
                REQ: begin
                    if (data_sram_addr_ok_i) begin
                        req_q    <= 1'b0;
                        doomed_q <= 1'b0;
                        if (doomed_q || wb_flush_i || ms_allowin_i) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DONE;
                        end
                    end else if (wb_flush_i) begin
                        doomed_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (ms_allowin_i || wb_flush_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign es_ready_go_o = !memOp || es_ale_o || es_ex_in_i || ms_ex_i ||
                           (state_q == DONE) ||
                           ((state_q == REQ) && data_sram_addr_ok_i && !doomed_q && !wb_flush_i);

    assign data_sram_req_o   = req_q;
    assign data_sram_wr_o    = wr_q;
    assign data_sram_size_o  = size_q;
    assign data_sram_wstrb_o = wstrb_q;
    assign data_sram_addr_o  = addr_q;
    assign data_sram_wdata_o = wdata_q;

    mem_resp_filter #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_resp_filter (
        .clk             (clk),
        .reset           (reset),
        .accept_i        (accept),
        .doomed_accept_i (doomedAccept),
        .data_ok_i       (data_sram_data_ok_i),
        .flush_i         (wb_flush_i),
        .can_issue_o     (canIssue),
        .ms_data_ok_o    (ms_data_ok_o)
    );

endmodule

// File: tb/tb_exe_mem_req.sv
// Scoreboard bench for exe_mem_req: request payloads and filtered data_ok are
// checked against a transaction-level model of live and flushed accesses.
module tb_exe_mem_req;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } reqT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        esValid = 1'b0, esRe = 1'b0, esWe = 1'b0;
    logic [1:0]  esSize = 2'd0;
    logic [31:0] esAddr = 32'h0, esData = 32'h0;
    logic        esExIn = 1'b0, msEx = 1'b0, wbFlush = 1'b0, msAllowin = 1'b1;
    logic        addrOk = 1'b0, dataOk = 1'b0;
    logic        sramReq, sramWr;
    logic [1:0]  sramSize;
    logic [3:0]  sramWstrb;
    logic [31:0] sramAddr, sramWdata;
    logic        esReadyGo, esAle, msDataOk;

    int  testsRun = 0;
    int  testsFailed = 0;
    int  cycle = 0;
    reqT expQ[$];
    bit  liveQ[$];
    int  dueQ[$];
    bit  curDead = 1'b0;
    int  addrDelay = 0;
    int  dataMin = 1;
    int  dataMax = 4;
    bit  allowRandom = 1'b0;

    exe_mem_req #(.MAX_OUTSTANDING(2)) dut (
        .clk                 (clk),
        .reset               (reset),
        .es_valid_i          (esValid),
        .es_mem_re_i         (esRe),
        .es_mem_we_i         (esWe),
        .es_size_i           (esSize),
        .es_addr_i           (esAddr),
        .es_st_data_i        (esData),
        .es_ex_in_i          (esExIn),
        .ms_ex_i             (msEx),
        .wb_flush_i          (wbFlush),
        .ms_allowin_i        (msAllowin),
        .data_sram_req_o     (sramReq),
        .data_sram_wr_o      (sramWr),
        .data_sram_size_o    (sramSize),
        .data_sram_wstrb_o   (sramWstrb),
        .data_sram_addr_o    (sramAddr),
        .data_sram_wdata_o   (sramWdata),
        .data_sram_addr_ok_i (addrOk),
        .data_sram_data_ok_i (dataOk),
        .es_ready_go_o       (esReadyGo),
        .es_ale_o            (esAle),
        .ms_data_ok_o        (msDataOk)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Memory model: addr_ok after addrDelay cycles of req, in-order data_ok later.
    initial begin : responder
        int waitCnt;
        waitCnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                addrOk = 1'b0;
                dataOk = 1'b0;
                waitCnt = 0;
                dueQ.delete();
            end else begin
                if (dueQ.size() > 0 && dueQ[0] <= cycle) begin
                    dataOk = 1'b1;
                    void'(dueQ.pop_front());
                end else begin
                    dataOk = 1'b0;
                end
                if (sramReq) begin
                    if (waitCnt >= addrDelay) begin
                        addrOk = 1'b1;
                        waitCnt = 0;
                        dueQ.push_back(cycle + int'($urandom_range(dataMax, dataMin)));
                    end else begin
                        addrOk = 1'b0;
                        waitCnt++;
                    end
                end else begin
                    addrOk = 1'b0;
                    waitCnt = 0;
                end
            end
        end
    end

    initial begin : allowinGen
        forever begin
            @(posedge clk);
            #1;
            msAllowin = allowRandom ? ($urandom_range(3, 0) != 0) : 1'b1;
        end
    end

    // Monitor: compares request channel and filtered data_ok against the model queues.
    initial begin : monitor
        reqT act;
        bit  live;
        bit  expReady;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (dataOk) begin
                    checkOutput("data_ok_inflight", liveQ.size() != 0, 1);
                    if (liveQ.size() != 0) begin
                        live = liveQ.pop_front();
                        checkOutput("ms_data_ok", msDataOk, live);
                    end
                end else begin
                    checkOutput("ms_data_ok_idle", msDataOk, 0);
                end
                if (sramReq) begin
                    act = {sramWr, sramSize, sramWstrb, sramAddr, sramWdata};
                    checkOutput("req_expected", expQ.size() != 0, 1);
                    if (expQ.size() != 0) checkOutput("req_payload", act, expQ[0]);
                    expReady = !(esValid && (esRe || esWe)) || (addrOk && !curDead && !wbFlush);
                    checkOutput("ready_go_req", esReadyGo, expReady);
                    if (addrOk) begin
                        if (expQ.size() != 0) void'(expQ.pop_front());
                        liveQ.push_back(!curDead);
                        curDead = 1'b0;
                    end else if (wbFlush) begin
                        curDead = 1'b1;
                    end
                end
                if (wbFlush) begin
                    foreach (liveQ[i]) liveQ[i] = 1'b0;
                end
            end
        end
    end

    // Presents one instruction to EXE and keeps it there until it hands off to MEM.
    task automatic applyStimulus(input bit re, input bit we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input bit exIn, input bit ex, input bit flushMode, input int delay);
        int  nBytes;
        int  n;
        bit  memOp, expAle, issue;
        reqT e;
        nBytes = 1 << size;
        memOp  = re || we;
        expAle = memOp && ((addr % nBytes) != 0);
        issue  = memOp && !expAle && !exIn && !ex;
        if (issue) begin
            e.wr    = we;
            e.size  = size;
            e.addr  = addr;
            e.wstrb = 4'b0000;
            e.wdata = 32'h0;
            for (int i = 0; i < 4; i++) begin
                if (we && i >= int'(addr % 4) && i < int'(addr % 4) + nBytes) e.wstrb[i] = 1'b1;
                e.wdata[8*i +: 8] = data[8*(i % nBytes) +: 8];
            end
            expQ.push_back(e);
        end
        addrDelay = delay;
        esValid = 1'b1; esRe = re; esWe = we; esSize = size;
        esAddr = addr; esData = data; esExIn = exIn; msEx = ex;
        @(negedge clk);
        checkOutput("es_ale", esAle, expAle);
        if (!issue) begin
            checkOutput("ready_go_noissue", esReadyGo, 1);
            checkOutput("no_req", sramReq, 0);
        end
        if (flushMode && issue) begin
            n = 0;
            while (!sramReq && n < 200) begin
                @(negedge clk);
                n++;
            end
            checkOutput("flush_req_seen", sramReq, 1);
            @(posedge clk);
            #1 wbFlush = 1'b1;
            @(posedge clk);
            #1;
            wbFlush = 1'b0;
            esValid = 1'b0; esRe = 1'b0; esWe = 1'b0;
            n = 0;
            @(negedge clk);
            while (sramReq && n < 200) begin
                @(negedge clk);
                n++;
            end
            checkOutput("flush_req_drop", sramReq, 0);
            @(posedge clk);
            #1;
        end else begin
            n = 0;
            while (!(esReadyGo && msAllowin) && n < 200) begin
                @(negedge clk);
                n++;
            end
            checkOutput("handoff", esReadyGo && msAllowin, 1);
            @(posedge clk);
            #1;
        end
        esValid = 1'b0; esRe = 1'b0; esWe = 1'b0; esExIn = 1'b0; msEx = 1'b0;
    endtask

    task automatic flushIdle();
        @(posedge clk);
        #1 wbFlush = 1'b1;
        @(posedge clk);
        #1 wbFlush = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((liveQ.size() != 0 || dueQ.size() != 0 || sramReq) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", (liveQ.size() == 0) && (dueQ.size() == 0) && !sramReq, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        bit          re, we, exIn, ex, fl;
        int          kind;
        logic [1:0]  size;
        logic [31:0] addr;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_req", sramReq, 0);
        checkOutput("reset_ready_go", esReadyGo, 1);
        checkOutput("reset_ms_data_ok", msDataOk, 0);
        checkOutput("reset_ale", esAle, 0);
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 1'b1, 2'd2, 32'h0000_1000, 32'hA1B2_C3D4, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h0000_1003, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h0000_1002, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h0000_1001, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h0000_1002, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 0);
        applyStimulus(0, 0, 2'd2, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 2'd2, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 3);
        drain();

        dataMin = 20; dataMax = 24;
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h0000_3004, 32'h0, 1'b0, 1'b0, 1'b0, 0);
        flushIdle();
        dataMin = 1; dataMax = 3;
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h0000_3008, 32'h0, 1'b0, 1'b0, 1'b0, 0);
        drain();

        applyStimulus(1'b1, 1'b0, 2'd2, 32'h0000_4000, 32'h0, 1'b0, 1'b0, 1'b1, 3);
        drain();

        allowRandom = 1'b1;
        dataMin = 1; dataMax = 6;
        for (int k = 0; k < 80; k++) begin
            kind = int'($urandom_range(9, 0));
            re   = (kind < 5);
            we   = (kind >= 5) && (kind < 9);
            size = 2'($urandom_range(2, 0));
            addr = $urandom();
            if ($urandom_range(3, 0) != 0) addr[1:0] = 2'b00;
            exIn = ($urandom_range(9, 0) == 0);
            ex   = ($urandom_range(9, 0) == 0);
            fl   = ($urandom_range(5, 0) == 0);
            applyStimulus(re, we, size, addr, $urandom(), exIn, ex, fl, int'($urandom_range(3, 0)));
            if ($urandom_range(9, 0) == 0) flushIdle();
        end
        drain();
        checkOutput("final_inflight", liveQ.size(), 0);
        checkOutput("final_expected_reqs", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
